// File: rtl/dcache_refill_unit.sv
// Data-cache miss handler: accepts one miss at a time from the cache, performs a
// single write-through store or a full in-order line refill over an OBI-style
// memory port, and streams refill words back to the cache as they arrive.
module dcache_refill_unit #(
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // Cache-side miss request
  input  logic                          miss_req_i,
  output logic                          miss_ack_o,
  input  logic [31:0]                   miss_addr_i,
  input  logic                          miss_we_i,
  input  logic [31:0]                   miss_wdata_i,
  input  logic [3:0]                    miss_be_i,
  // Refill return and status
  output logic                          fill_valid_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
  output logic [31:0]                   fill_data_o,
  output logic                          fill_last_o,
  output logic                          wr_done_o,
  output logic                          busy_o,
  output logic                          protocol_err_o,
  // Memory port
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [31:0]                   mem_rdata_i
);

  localparam int unsigned     IdxW    = $clog2(LINE_WORDS);
  localparam int unsigned     OffW    = IdxW + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);
  localparam logic [2:0]      MaxOut  = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e          state_q;
  logic [31:2]     addr_q;     // word address (write) or line base (read)
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [IdxW-1:0] req_idx_q;  // next word of the line to request
  logic [IdxW-1:0] rsp_idx_q;  // responses received so far
  logic [2:0]      outst_q;    // granted but unanswered requests
  logic            wr_gnt_q;
  logic            wr_done_q;
  logic            err_q;

  logic            gnt_ok;
  logic            rsp_ok;
  logic            stray_evt;
  logic [1:0]      unused_addr_lsb;

  // Byte offset is always cleared on the memory side.
  assign unused_addr_lsb = miss_addr_i[1:0];

  // Memory-port request and payload, decoded from registered state only.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    unique case (state_q)
      StWrite: begin
        mem_req_o   = !wr_gnt_q && (outst_q < MaxOut);
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q, 2'b00};
        mem_wdata_o = wdata_q;
        mem_be_o    = be_q;
      end
      StRead: begin
        mem_req_o  = outst_q < MaxOut;
        // Offset spliced in, never added, so the address cannot leave the line.
        mem_addr_o = {addr_q[31:OffW], req_idx_q, 2'b00};
        mem_be_o   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign gnt_ok    = mem_req_o && mem_gnt_i;
  assign rsp_ok    = mem_rvalid_i && (outst_q != 3'd0);
  assign stray_evt = (mem_rvalid_i && (outst_q == 3'd0)) || (mem_gnt_i && !mem_req_o);

  assign miss_ack_o     = miss_req_i && (state_q == StIdle) && !rst_i;
  assign fill_valid_o   = rsp_ok && ((state_q == StRead) || (state_q == StDrain));
  assign fill_idx_o     = rsp_idx_q;
  assign fill_data_o    = fill_valid_o ? mem_rdata_i : 32'h0;
  assign fill_last_o    = fill_valid_o && (rsp_idx_q == LastIdx);
  assign wr_done_o      = wr_done_q;
  assign busy_o         = state_q != StIdle;
  assign protocol_err_o = err_q;

  // Control FSM, credit counter and sticky protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      req_idx_q <= '0;
      rsp_idx_q <= '0;
      outst_q   <= '0;
      wr_gnt_q  <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (stray_evt) err_q <= 1'b1;

      if (gnt_ok && !rsp_ok) begin
        outst_q <= outst_q + 3'd1;
      end else if (!gnt_ok && rsp_ok) begin
        outst_q <= outst_q - 3'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (miss_ack_o) begin
            wdata_q   <= miss_wdata_i;
            be_q      <= miss_be_i;
            req_idx_q <= '0;
            rsp_idx_q <= '0;
            wr_gnt_q  <= 1'b0;
            if (miss_we_i) begin
              addr_q  <= miss_addr_i[31:2];
              state_q <= StWrite;
            end else begin
              addr_q  <= {miss_addr_i[31:OffW], IdxW'(0)};
              state_q <= StRead;
            end
          end
        end
        StWrite: begin
          // wr_done_q holds for exactly one cycle before returning to idle.
          if (wr_done_q) begin
            wr_done_q <= 1'b0;
            state_q   <= StIdle;
          end else begin
            if (gnt_ok) wr_gnt_q <= 1'b1;
            if (rsp_ok) wr_done_q <= 1'b1;
          end
        end
        StRead: begin
          if (rsp_ok) rsp_idx_q <= rsp_idx_q + 1'b1;
          if (gnt_ok) begin
            req_idx_q <= req_idx_q + 1'b1;
            if (req_idx_q == LastIdx) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (rsp_ok) begin
            rsp_idx_q <= rsp_idx_q + 1'b1;
            if (rsp_idx_q == LastIdx) state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for dcache_refill_unit: a randomized memory responder, a
// line-level reference model producing expected requests/fills, and a negedge
// monitor that pops and compares whatever the DUT presents.
module tb_dcache_refill_unit;

  localparam int unsigned LW   = 4;
  localparam int unsigned MAXO = 2;
  localparam int unsigned IW   = $clog2(LW);

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req_i, miss_we_i;
  logic [31:0]   miss_addr_i, miss_wdata_i;
  logic [3:0]    miss_be_i;
  logic          miss_ack_o, fill_valid_o, fill_last_o, wr_done_o, busy_o, protocol_err_o;
  logic [IW-1:0] fill_idx_o;
  logic [31:0]   fill_data_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]    mem_be_o;

  always #5 clk = ~clk;

  dcache_refill_unit #(.LINE_WORDS(LW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .miss_req_i(miss_req_i), .miss_ack_o(miss_ack_o), .miss_addr_i(miss_addr_i),
    .miss_we_i(miss_we_i), .miss_wdata_i(miss_wdata_i), .miss_be_i(miss_be_i),
    .fill_valid_o(fill_valid_o), .fill_idx_o(fill_idx_o), .fill_data_o(fill_data_o),
    .fill_last_o(fill_last_o), .wr_done_o(wr_done_o), .busy_o(busy_o),
    .protocol_err_o(protocol_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} req_t;
  typedef struct packed {logic [IW-1:0] idx; logic [31:0] data; logic last;} fill_t;
  typedef struct packed {int unsigned due; logic [31:0] addr; logic we;} pend_t;

  req_t  exp_req[$];
  fill_t exp_fill[$];
  pend_t pend[$];

  int          n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, last_due = 0;
  int          out_cnt = 0, fills_seen = 0, gnt_wait = 0;
  int          gnt_pct = 100, gnt_delay = 0, lat_min = 1, lat_max = 1;
  bit          stray_rv = 0, cur_stray = 0, cur_we = 0, wd_due = 0, prev_hold = 0;
  bit          model_busy = 0;
  req_t        prev_pl;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  // Reference model: what a miss must produce on the memory port and fill port.
  task automatic push_expect(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be);
    logic [31:0] base, a;
    if (we) begin
      exp_req.push_back('{addr: addr & ~32'h3, we: 1'b1, be: be, wdata: wd});
    end else begin
      base = addr & ~(32'(LW * 4) - 32'd1);
      for (int k = 0; k < LW; k++) begin
        a = base | 32'(4 * k);
        exp_req.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0});
        exp_fill.push_back('{idx: IW'(k), data: mem_data(a), last: (k == LW - 1)});
      end
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    bit acked = 0;
    @(posedge clk); #1;
    miss_req_i = 1'b1; miss_we_i = we; miss_addr_i = addr; miss_wdata_i = wd; miss_be_i = be;
    for (int i = 0; i < 3000 && !acked; i++) begin
      @(negedge clk);
      if (miss_ack_o) acked = 1;
    end
    if (!acked) fail_msg($sformatf("miss_ack_timeout: no accept for addr %h", addr));
    else push_expect(we, addr, wd, be);
    @(posedge clk); #1;
    miss_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (!model_busy && exp_req.size() == 0 && exp_fill.size() == 0 && pend.size() == 0 && !wd_due)
        ok = 1;
    end
    if (!ok) fail_msg($sformatf("%s_timeout: %0d reqs, %0d fills still expected", tag,
                                exp_req.size(), exp_fill.size()));
    @(negedge clk);
    chk({tag, "_busy_low"}, busy_o, 1'b0);
  endtask

  task automatic flush_model();
    exp_req.delete(); exp_fill.delete(); pend.delete();
    out_cnt = 0; gnt_wait = 0; wd_due = 0; prev_hold = 0; model_busy = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ctrl"}, {miss_ack_o, fill_valid_o, fill_last_o, wr_done_o, busy_o, protocol_err_o,
                         mem_req_o, mem_we_o}, 8'h0);
    chk({tag, "_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_be_idx"}, {mem_be_o, fill_idx_o}, '0);
    chk({tag, "_fill_data"}, fill_data_o, 32'h0);
  endtask

  // Memory responder: in-order responses after a random latency, random grants.
  initial begin
    pend_t p;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      cur_stray = 0;
      cur_we    = 0;
      if (rst) begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        pend.delete();
      end else begin
        if (stray_rv) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; cur_stray = 1; stray_rv = 0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          mem_rvalid_i = 1'b1; mem_rdata_i = mem_data(p.addr); cur_we = p.we;
        end else begin
          mem_rvalid_i = 1'b0;
        end
        mem_gnt_i = mem_req_o && (gnt_wait >= gnt_delay) && (int'($urandom_range(99)) < gnt_pct);
      end
    end
  end

  // Monitor: compare every handshake, fill and status output against the model.
  initial begin
    req_t        e;
    fill_t       f;
    bit          grant, rsp_evt, exp_fv, exp_ack, done_evt;
    int unsigned due;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_ack  = miss_req_i && !model_busy;
        done_evt = 0;
        chk("busy", busy_o, model_busy);
        if (miss_req_i || miss_ack_o) chk("miss_ack", miss_ack_o, exp_ack);

        if (prev_hold && mem_req_o) begin
          chk("hold_addr", mem_addr_o, prev_pl.addr);
          chk("hold_ctl", {mem_we_o, mem_be_o, mem_wdata_o}, {prev_pl.we, prev_pl.be, prev_pl.wdata});
        end
        if (out_cnt >= MAXO) chk("req_at_max_outstanding", mem_req_o, 1'b0);

        grant = mem_req_o && mem_gnt_i;
        if (grant) begin
          if (exp_req.size() == 0) begin
            fail_msg($sformatf("req_unexpected: addr %h we %b, none expected", mem_addr_o, mem_we_o));
            e = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o};
          end else begin
            e = exp_req.pop_front();
            chk("req_addr", mem_addr_o, e.addr);
            chk("req_we", mem_we_o, e.we);
            chk("req_be", mem_be_o, e.be);
            if (e.we) chk("req_wdata", mem_wdata_o, e.wdata);
          end
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{due: due, addr: mem_addr_o, we: e.we});
          gnt_wait = 0;
        end else if (mem_req_o) begin
          gnt_wait++;
        end
        prev_hold = mem_req_o && !mem_gnt_i;
        prev_pl   = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o};

        rsp_evt = mem_rvalid_i && !cur_stray;
        exp_fv  = rsp_evt && !cur_we;
        if (exp_fv || fill_valid_o) begin
          chk("fill_valid", fill_valid_o, exp_fv);
          if (exp_fv) begin
            if (exp_fill.size() == 0) begin
              fail_msg($sformatf("fill_unexpected: idx %0d data %h", fill_idx_o, fill_data_o));
            end else begin
              f = exp_fill.pop_front();
              chk("fill_idx", fill_idx_o, f.idx);
              chk("fill_data", fill_data_o, f.data);
              chk("fill_last", fill_last_o, f.last);
              if (f.last) done_evt = 1;
            end
          end
        end
        if (fill_valid_o) fills_seen++;

        if (wd_due || wr_done_o) chk("wr_done", wr_done_o, wd_due);
        if (wd_due) done_evt = 1;
        wd_due = rsp_evt && cur_we;

        model_busy = model_busy ? !done_evt : exp_ack;
        out_cnt = out_cnt + int'(grant) - int'(rsp_evt);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit seen;
    logic [31:0] a;
    rst = 1'b1;
    miss_req_i = 1'b1; miss_we_i = 1'b0; miss_addr_i = 32'h0; miss_wdata_i = 32'h0; miss_be_i = 4'h0;
    #3;
    reset_checks("reset_initial");
    miss_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Read miss, grant always, latency 1.
    gnt_pct = 100; gnt_delay = 0; lat_min = 1; lat_max = 1;
    issue(1'b0, 32'h0000_1238, 32'h0, 4'h0);
    wait_idle("read_basic");

    // Write-through.
    issue(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 4'b0011);
    wait_idle("write_basic");

    // Backpressure: first grant held off 3 cycles, latency 4 fills the credits.
    gnt_delay = 3; lat_min = 4; lat_max = 4;
    issue(1'b0, 32'h0000_3014, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (pend.size() > 0) seen = 1;
    end
    if (!seen) fail_msg("backpressure_grant_timeout: first read never granted");
    gnt_delay = 0;
    wait_idle("backpressure");
    issue(1'b1, 32'h0000_3100, 32'h1234_5678, 4'b1100);
    wait_idle("backpressure_wr");

    // Grant and response coinciding at one outstanding.
    lat_min = 1; lat_max = 2;
    issue(1'b0, 32'h0000_4404, 32'h0, 4'h0);
    wait_idle("same_cycle");

    // Randomized traffic, including the top line of the address space.
    for (int t = 0; t < 40; t++) begin
      gnt_pct   = $urandom_range(100, 30);
      gnt_delay = $urandom_range(2);
      lat_min   = $urandom_range(3, 1);
      lat_max   = lat_min + int'($urandom_range(3));
      a = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      issue($urandom_range(9) < 4, a, $urandom, 4'($urandom_range(15)));
    end
    wait_idle("random");
    chk("protocol_err_clean", protocol_err_o, 1'b0);

    // Reset in the middle of a refill.
    gnt_pct = 100; gnt_delay = 0; lat_min = 3; lat_max = 3;
    start = fills_seen;
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (fills_seen >= start + 2) seen = 1;
    end
    if (!seen) fail_msg("reset_mid_fill_timeout: two fills never observed");
    @(posedge clk); #3;
    rst = 1'b1;
    miss_req_i = 1'b1;
    #1;
    reset_checks("reset_mid");
    miss_req_i = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    lat_min = 1; lat_max = 2;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    wait_idle("after_reset");
    chk("after_reset_err", protocol_err_o, 1'b0);

    // Stray response while idle sets the sticky error.
    @(negedge clk);
    stray_rv = 1;
    repeat (3) @(negedge clk);
    chk("stray_err_set", protocol_err_o, 1'b1);
    issue(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    wait_idle("after_stray");
    chk("stray_err_sticky", protocol_err_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
